// File: rtl/timer_scheduler_pkg.sv
// Shared types and register-map constants for the deadline-channel timer scheduler.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACTIVE
  } state_t;

  localparam int MAX_CH = 8;
  localparam int ID_W   = 3;

  localparam logic [31:0] GCTRL_ADDR   = 32'h0000_0000;
  localparam logic [31:0] STATUS_ADDR  = 32'h0000_0004;
  localparam logic [31:0] ACK_ADDR     = 32'h0000_0008;
  localparam logic [31:0] OVR_CLR_ADDR = 32'h0000_000C;
  localparam logic [31:0] CH_BASE      = 32'h0000_0010;
  localparam logic [31:0] CH_STRIDE    = 32'h0000_0010;

  localparam logic [3:0] CCTRL_OFF    = 4'h0;
  localparam logic [3:0] DEADLINE_OFF = 4'h4;
  localparam logic [3:0] PERIOD_OFF   = 4'h8;

  localparam int CCTRL_EN       = 0;
  localparam int CCTRL_PERIODIC = 1;

endpackage

// File: rtl/timer_scheduler_if.sv
// Peripheral register-access bus shared with the timer block.
interface timer_scheduler_if;
  logic [31:0] address;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output address, wr_en, rd_en, wr_data, input rd_data);
  modport slave  (input address, wr_en, rd_en, wr_data, output rd_data);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts at last+1 and wraps.
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [WIDTH-1:0] grant,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant = '0;
    id    = '0;
    valid = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (!valid && req[j] && (j == (int'(last) + i) % WIDTH)) begin
          valid    = 1'b1;
          grant[j] = 1'b1;
          id       = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/timer_scheduler.sv
// Multiplexes NUM_CH deadline channels onto one free-running count and one
// level interrupt, serviced round-robin and held until software acknowledges.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                clk,
  input  logic                rst,
  timer_scheduler_if.slave    bus,
  input  logic [31:0]         timer,
  output logic                irq,
  output logic [ID_W-1:0]     irq_id
);

  state_t            state;
  logic              gctrl_en;
  logic [ID_W-1:0]   last_grant;
  logic [NUM_CH-1:0] pending, overrun, fire, en, periodic;
  logic [NUM_CH-1:0] wr_cctrl, wr_deadline, wr_period, grant_clr, arb_grant;
  logic [31:0]       deadline [NUM_CH];
  logic [31:0]       period   [NUM_CH];
  logic [ID_W-1:0]   arb_id;
  logic              arb_valid;
  logic [31:0]       ch_off, rd;
  logic              ch_in, wr_gctrl, wr_ack, wr_ovr_clr;
  logic [ID_W-1:0]   ch_sel;
  logic [3:0]        reg_off;

  assign ch_off     = bus.address - CH_BASE;
  assign ch_in      = (bus.address >= CH_BASE) && (ch_off < CH_STRIDE * NUM_CH);
  assign ch_sel     = ch_off[6:4];
  assign reg_off    = ch_off[3:0];
  assign wr_gctrl   = bus.wr_en && (bus.address == GCTRL_ADDR);
  assign wr_ack     = bus.wr_en && (bus.address == ACK_ADDR);
  assign wr_ovr_clr = bus.wr_en && (bus.address == OVR_CLR_ADDR);
  assign grant_clr  = (state == GRANT) ? arb_grant : '0;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic        en_q, per_q, pend_q, ovr_q, sw_hit, reload;
    logic [31:0] dl_q, prd_q;

    assign wr_cctrl[c]    = bus.wr_en && ch_in && (ch_sel == ID_W'(c)) && (reg_off == CCTRL_OFF);
    assign wr_deadline[c] = bus.wr_en && ch_in && (ch_sel == ID_W'(c)) && (reg_off == DEADLINE_OFF);
    assign wr_period[c]   = bus.wr_en && ch_in && (ch_sel == ID_W'(c)) && (reg_off == PERIOD_OFF);

    // Difference taken mod 2^32 so the deadline compare survives counter wrap.
    assign sw_hit  = wr_cctrl[c] || wr_deadline[c];
    assign fire[c] = en_q && !sw_hit && ($signed(timer - dl_q) >= 0);
    assign reload  = per_q && (prd_q != '0);

    always_ff @(posedge clk) begin
      // NOTE: deadline/period storage is reset too, so the whole register map reads 0 after reset.
      if (!rst) begin
        en_q   <= 1'b0;
        per_q  <= 1'b0;
        pend_q <= 1'b0;
        ovr_q  <= 1'b0;
        dl_q   <= '0;
        prd_q  <= '0;
      end else begin
        if (wr_cctrl[c]) begin
          en_q  <= bus.wr_data[CCTRL_EN];
          per_q <= bus.wr_data[CCTRL_PERIODIC];
        end else if (fire[c] && !reload) begin
          en_q <= 1'b0;
        end

        if (wr_deadline[c])        dl_q <= bus.wr_data;
        else if (fire[c] && reload) dl_q <= dl_q + prd_q;

        if (wr_period[c]) prd_q <= bus.wr_data;

        if (sw_hit)            pend_q <= 1'b0;
        else if (fire[c])      pend_q <= 1'b1;
        else if (grant_clr[c]) pend_q <= 1'b0;

        // A fire landing on a still-pending event that is not being granted is lost.
        if (fire[c] && pend_q && !grant_clr[c])    ovr_q <= 1'b1;
        else if (wr_ovr_clr && bus.wr_data[c])      ovr_q <= 1'b0;
      end
    end

    assign en[c]       = en_q;
    assign periodic[c] = per_q;
    assign pending[c]  = pend_q;
    assign overrun[c]  = ovr_q;
    assign deadline[c] = dl_q;
    assign period[c]   = prd_q;
  end

  rr_arbiter #(.WIDTH(NUM_CH)) u_arb (
    .req   (pending),
    .last  (last_grant),
    .grant (arb_grant),
    .id    (arb_id),
    .valid (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) gctrl_en <= 1'b0;
    else if (wr_gctrl) gctrl_en <= bus.wr_data[0];
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_id     <= '0;
      last_grant <= ID_W'(NUM_CH - 1);
    end else begin
      case (state)
        IDLE: if (gctrl_en && |pending) state <= GRANT;
        GRANT: begin
          if (arb_valid) begin
            irq_id     <= arb_id;
            last_grant <= arb_id;
            irq        <= 1'b1;
            state      <= ACTIVE;
          end else begin
            state <= IDLE;
          end
        end
        ACTIVE: begin
          if (wr_ack) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    if (bus.rd_en) begin
      case (bus.address)
        GCTRL_ADDR:  rd = {31'b0, gctrl_en};
        STATUS_ADDR: rd = {irq, 12'b0, irq_id, 8'(overrun), 8'(pending)};
        default:     ;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_in && (ch_sel == ID_W'(c))) begin
          case (reg_off)
            CCTRL_OFF:    rd = {30'b0, periodic[c], en[c]};
            DEADLINE_OFF: rd = deadline[c];
            PERIOD_OFF:   rd = period[c];
            default:      ;
          endcase
        end
      end
    end
  end

  assign bus.rd_data = rd;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: expected grant ids are queued when a fire
// is provoked and popped when irq rises; register reads are checked in place.
module tb_timer_scheduler;
  import timer_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [31:0] timer = '0;
  logic        irq;
  logic [2:0]  irq_id;
  logic [31:0] d;
  logic        early;
  int          checks = 0;
  int          failures = 0;
  logic [2:0]  sb [$];

  timer_scheduler_if bus ();

  timer_scheduler #(.NUM_CH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .timer  (timer),
    .irq    (irq),
    .irq_id (irq_id)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ch_addr(input int c, input logic [3:0] off);
    return CH_BASE + CH_STRIDE * 32'(c) + {28'b0, off};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Samples land 1 time unit after the rising edge; the count advances there too.
  task automatic tick();
    @(posedge clk);
    #1;
    if (run) timer = timer + 32'd1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    bus.address = a;
    bus.wr_data = v;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    bus.address = a;
    bus.rd_en   = 1'b1;
    #1;
    v = bus.rd_data;
    bus.rd_en   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic run_to(input logic [31:0] t);
    int n = 0;
    while (timer != t && n < 2000) begin
      tick();
      n++;
    end
    if (timer != t) begin
      checks++;
      failures++;
      $error("FAIL run_to observed=0x%08h expected=0x%08h", timer, t);
    end
  endtask

  // Wait for irq, then compare latency and the granted id against the scoreboard.
  task automatic await_irq(input string tag, input int exp_lat);
    int         n = 0;
    logic [2:0] exp_id;
    while (!irq && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_irq"}, 32'(irq), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    exp_id = (sb.size() > 0) ? sb.pop_front() : 3'h7;
    check({tag, "_id"}, 32'(irq_id), 32'(exp_id));
  endtask

  task automatic ack(input string tag);
    bus_write(ACK_ADDR, 32'h1);
    check({tag, "_ack_low"}, 32'(irq), 32'd0);
  endtask

  initial begin
    bus.address = '0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;

    // Reset state
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    read_check("rst_status", STATUS_ADDR, 32'h0);
    read_check("rst_gctrl", GCTRL_ADDR, 32'h0);
    read_check("rst_cctrl0", ch_addr(0, CCTRL_OFF), 32'h0);
    read_check("unmapped", 32'h0000_0100, 32'h0);

    // Channel 0 one-shot at 100
    timer = 32'd90;
    bus_write(ch_addr(0, DEADLINE_OFF), 32'd100);
    bus_write(ch_addr(0, CCTRL_OFF), 32'h1);
    bus_write(GCTRL_ADDR, 32'h1);
    run = 1'b1;
    run_to(32'd100);
    sb.push_back(3'd0);
    tick();
    check("os_irq_at_k", 32'(irq), 32'd0);
    read_check("os_pending", STATUS_ADDR, 32'h0000_0001);
    read_check("os_en_cleared", ch_addr(0, CCTRL_OFF), 32'h0);
    await_irq("os", 2);
    read_check("os_status_active", STATUS_ADDR, 32'h8000_0000);
    ack("os");

    // Channel 1 periodic: 50, 70, 90
    run = 1'b0;
    timer = 32'd40;
    bus_write(ch_addr(1, PERIOD_OFF), 32'd20);
    bus_write(ch_addr(1, DEADLINE_OFF), 32'd50);
    bus_write(ch_addr(1, CCTRL_OFF), 32'h3);
    run = 1'b1;
    run_to(32'd50);
    sb.push_back(3'd1);
    await_irq("per50", 3);
    ack("per50");
    run_to(32'd70);
    sb.push_back(3'd1);
    await_irq("per70", 3);
    ack("per70");
    run_to(32'd90);
    sb.push_back(3'd1);
    await_irq("per90", 3);
    ack("per90");
    read_check("per_deadline", ch_addr(1, DEADLINE_OFF), 32'd110);
    read_check("per_cctrl", ch_addr(1, CCTRL_OFF), 32'h3);
    bus_write(ch_addr(1, CCTRL_OFF), 32'h0);

    // Wrap-around: deadline 4, count starts at 0xFFFF_FFF0
    run = 1'b0;
    timer = 32'hFFFF_FFF0;
    bus_write(ch_addr(0, DEADLINE_OFF), 32'h4);
    bus_write(ch_addr(0, CCTRL_OFF), 32'h1);
    run = 1'b1;
    early = 1'b0;
    for (int n = 0; n < 100 && timer != 32'h4; n++) begin
      tick();
      bus_read(STATUS_ADDR, d);
      if (irq || d[0]) early = 1'b1;
    end
    check("wrap_no_early", 32'(early), 32'd0);
    sb.push_back(3'd0);
    await_irq("wrap", 3);
    ack("wrap");

    // Arbitration round 1 from reset pointer: 0, 2, 3
    rst = 1'b0;
    tick();
    rst = 1'b1;
    run = 1'b0;
    timer = 32'd190;
    for (int c = 0; c < 4; c++) begin
      if (c != 1) begin
        bus_write(ch_addr(c, DEADLINE_OFF), 32'd200);
        bus_write(ch_addr(c, CCTRL_OFF), 32'h1);
      end
    end
    bus_write(GCTRL_ADDR, 32'h1);
    run = 1'b1;
    run_to(32'd200);
    sb.push_back(3'd0);
    sb.push_back(3'd2);
    sb.push_back(3'd3);
    await_irq("arb_a", 3);
    ack("arb_a");
    await_irq("arb_b", 2);
    ack("arb_b");
    await_irq("arb_c", 2);
    ack("arb_c");

    // Round 2: move pointer to 0, then ch0 and ch3 pending together -> 3 first
    bus_write(ch_addr(0, DEADLINE_OFF), 32'd300);
    bus_write(ch_addr(0, CCTRL_OFF), 32'h1);
    run_to(32'd300);
    sb.push_back(3'd0);
    await_irq("ptr", 3);
    ack("ptr");
    bus_write(GCTRL_ADDR, 32'h0);
    bus_write(ch_addr(0, DEADLINE_OFF), 32'd320);
    bus_write(ch_addr(3, DEADLINE_OFF), 32'd320);
    bus_write(ch_addr(0, CCTRL_OFF), 32'h1);
    bus_write(ch_addr(3, CCTRL_OFF), 32'h1);
    run_to(32'd320);
    tick();
    tick();
    tick();
    check("gated_irq", 32'(irq), 32'd0);
    read_check("gated_status", STATUS_ADDR, 32'h0000_0009);
    bus_write(GCTRL_ADDR, 32'h1);
    sb.push_back(3'd3);
    sb.push_back(3'd0);
    await_irq("rr2_a", 2);
    ack("rr2_a");
    await_irq("rr2_b", 2);
    ack("rr2_b");

    // Overrun on ch2 while ch1 stays in service
    run = 1'b0;
    timer = 32'd390;
    bus_write(ch_addr(1, DEADLINE_OFF), 32'd400);
    bus_write(ch_addr(1, CCTRL_OFF), 32'h1);
    bus_write(ch_addr(2, PERIOD_OFF), 32'd5);
    bus_write(ch_addr(2, DEADLINE_OFF), 32'd410);
    bus_write(ch_addr(2, CCTRL_OFF), 32'h3);
    run = 1'b1;
    run_to(32'd400);
    sb.push_back(3'd1);
    await_irq("ovr_svc", 3);
    run_to(32'd418);
    read_check("ovr_set", STATUS_ADDR, 32'h8001_0404);
    bus_write(ch_addr(2, CCTRL_OFF), 32'h0);
    read_check("ovr_kept", STATUS_ADDR, 32'h8001_0400);
    bus_write(OVR_CLR_ADDR, 32'h4);
    read_check("ovr_cleared", STATUS_ADDR, 32'h8001_0000);
    ack("ovr_svc");

    // Deadline write in the fire cycle wins
    run = 1'b0;
    timer = 32'd490;
    bus_write(ch_addr(0, DEADLINE_OFF), 32'd500);
    bus_write(ch_addr(0, CCTRL_OFF), 32'h1);
    run = 1'b1;
    run_to(32'd500);
    bus_write(ch_addr(0, DEADLINE_OFF), 32'd600);
    bus_read(STATUS_ADDR, d);
    check("prec_pending", d & 32'hFF, 32'h0);
    tick();
    tick();
    tick();
    check("prec_no_irq", 32'(irq), 32'd0);
    read_check("prec_deadline", ch_addr(0, DEADLINE_OFF), 32'd600);

    // Reset while ACTIVE
    run_to(32'd600);
    sb.push_back(3'd0);
    await_irq("rst_act", 3);
    rst = 1'b0;
    tick();
    check("rst_act_irq", 32'(irq), 32'd0);
    read_check("rst_act_status", STATUS_ADDR, 32'h0);
    rst = 1'b1;
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Multiplexes `NUM_CH` software deadline channels onto the single free-running `timer` count produced by the peripheral timer. Each channel holds a deadline and an optional reload period. When the shared count reaches a channel's deadline, that channel becomes pending. A round-robin arbiter presents one pending channel at a time on a single interrupt line, and the interrupt is held until software acknowledges it. The block sits on the peripheral bus beside the timer and shares its register-access protocol.

## Interface
- `NUM_CH`, default 4, number of channels, legal range 1..8.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-low reset.
- `address` input 32: byte address of the register access, offset within the block.
- `wr_en` input 1: register write strobe, one access per cycle.
- `rd_en` input 1: register read strobe.
- `wr_data` input 32: write data.
- `rd_data` output 32: combinational read data; 0 when `rd_en` is low or the address is unmapped.
- `timer` input 32: free-running count from the timer peripheral.
- `irq` output 1: interrupt, level, held until acknowledged.
- `irq_id` output 3: channel in service; valid while `irq` is high.

## Operation
- Register map:
  - 0x00 GCTRL: bit0 global enable.
  - 0x04 STATUS, read-only: [7:0] pending, [15:8] overrun, [18:16] in-service id, bit31 `irq`.
  - 0x08 ACK, write-only: any write while ACTIVE ends service. A write in any other state has no effect.
  - 0x0C OVR_CLR: writing 1s clears the corresponding overrun bits.
  - Channel c at 0x10+0x10*c: +0 CCTRL (bit0 en, bit1 periodic), +4 DEADLINE, +8 PERIOD.
- Fire condition for channel c: `en` set and `$signed(timer - deadline) >= 0`. The difference is computed mod 2^32, so the comparison is wrap-safe.
- On fire:
  - The pending bit is set.
  - If `periodic` is set and PERIOD != 0, DEADLINE <= DEADLINE + PERIOD, wrapping mod 2^32.
  - Otherwise `en` is cleared (one-shot). A periodic channel with PERIOD = 0 behaves as one-shot.
- If a channel fires while its pending bit is already set, its overrun bit is set and the event is dropped.
- A software write to a channel's CCTRL or DEADLINE clears that channel's pending bit and suppresses any fire that cycle; the write takes precedence.
- FSM states and transitions:
  - IDLE -> GRANT when GCTRL.en and any pending bit is set.
  - GRANT, one cycle: the arbiter picks a channel, round-robin starting at last_grant+1. The id is latched, that channel's pending bit is cleared, last_grant is updated, and the FSM moves to ACTIVE.
  - ACTIVE: `irq` = 1. An ACK write returns the FSM to IDLE.
- Clearing GCTRL.en while ACTIVE does not drop `irq`; it only blocks new grants.
- While a channel is in service it may fire again and become pending again. It is then eligible on a later grant.
- Reset values:
  - All registers are 0, including GCTRL.en and every channel's `en`.
  - FSM is IDLE, last_grant = NUM_CH-1, `irq` = 0, `irq_id` = 0.
- A reset asserted mid-service drops `irq` on the next edge; no acknowledge is needed.

## Timing
- The fire condition is evaluated combinationally on `timer`. The pending bit registers at edge k+0, where k is the first edge at which the condition holds.
- The GRANT state is entered at edge k+1 and `irq` rises at edge k+2. Fire-to-`irq` latency is therefore 2 cycles.
- The pending-to-DEADLINE reload happens at the same edge as the pending set, so a periodic channel re-fires exactly PERIOD counts later.
- An ACK write at edge a makes `irq` low from edge a. The FSM is in IDLE after a. If work is pending, GRANT is entered at a+1 and `irq` rises at a+2.
- Minimum `irq` low gap between back-to-back services: 2 cycles.
- Register writes take effect at the write edge. Reads reflect state before that edge.

## Structure
- Package `timer_sched_pkg` holds:
  - the FSM state enum {IDLE, GRANT, ACTIVE};
  - the register offset constants;
  - the CCTRL bit indices;
  - the channel stride constant (0x10);
  - the `NUM_CH` maximum (8).
- Sub-module `rr_arbiter`, parameterised by width: request vector plus last-grant pointer in, one-hot grant and encoded id out. It is purely combinational, and last_grant is stored in the parent.
- Per-channel registers are a generate loop inside `timer_scheduler`.

## Test plan
- Channel 0 one-shot: DEADLINE = 100, en = 1, GCTRL = 1, `timer` ramps from 90. Required: `irq` rises 2 cycles after `timer` = 100, `irq_id` = 0, ch0 `en` reads 0. ACK drops `irq`.
- Channel 1 periodic: DEADLINE = 50, PERIOD = 20. Required: fires at 50, 70 and 90, and DEADLINE reads 110 after the third fire.
- Wrap-around: DEADLINE = 0x0000_0004, `timer` runs from 0xFFFF_FFF0. Required: no fire before the wrap; fires at `timer` = 4.
- Arbitration: channels 0, 2 and 3 fire on the same cycle. Required: grants are issued in order 0, 2, 3 across three ACKs. A second round from last_grant = 0 with ch0 and ch3 pending grants 3 first.
- Overrun: ch2 periodic with PERIOD = 5, never acked while ch1 is in service. Required: overrun bit 2 set. OVR_CLR = 0x4 clears it.
- Precedence and reset: a write to ch0 DEADLINE in the same cycle as its fire leaves pending = 0. Asserting `rst` low while ACTIVE makes `irq` = 0 and STATUS = 0 at the next edge.
